// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 matrix keypad scanner.
// Holds matrix dimensions, the debounce FSM state encoding, the per-frame
// classification and small row-decoding helpers used by keypad_scanner.
package keypad_pkg;

  localparam int N_ROWS = 4;
  localparam int N_COLS = 4;

  // Key code = {row[1:0], col[1:0]}, i.e. index row*4+col.
  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAND    = 2'd1,
    ST_PRESSED = 2'd2,
    ST_RELEASE = 2'd3
  } scan_state_e;

  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_kind_e;

  // Number of active (high) rows in one column sample, 0..4.
  function automatic logic [2:0] row_hit_count(input logic [N_ROWS-1:0] hits);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int r = 0; r < N_ROWS; r++) begin
      cnt = cnt + {2'b00, hits[r]};
    end
    return cnt;
  endfunction

  // Lowest active row index; 0 when no row is active (caller qualifies).
  function automatic logic [1:0] lowest_row(input logic [N_ROWS-1:0] hits);
    logic [1:0] idx;
    if (hits[0]) begin
      idx = 2'd0;
    end else if (hits[1]) begin
      idx = 2'd1;
    end else if (hits[2]) begin
      idx = 2'd2;
    end else if (hits[3]) begin
      idx = 2'd3;
    end else begin
      idx = 2'd0;
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// keypad_row_sync: two-flop synchroniser for the active-low row inputs.
// Both stages reset to all-ones so that no key appears pressed out of reset.
module keypad_row_sync
  import keypad_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_ROWS-1:0] i_row,
  output logic [N_ROWS-1:0] o_row
);

  logic [N_ROWS-1:0] meta_q;
  logic [N_ROWS-1:0] sync_q;

  // Two-stage capture of the asynchronous row lines.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= i_row;
      sync_q <= meta_q;
    end
  end

  assign o_row = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, classifies each full frame
// (4 columns) as NONE/SINGLE/MULTI, and debounces whole frames so that one
// code strobe is emitted per debounced press; holds and releases emit nothing.
// Optional build macro: KEYPAD_GHOST_REJECT_EN -- when defined, frames with
// more than one key down are classified MULTI and never accepted as a press;
// when undefined, such frames resolve to the lowest key index.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 16,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [3:0] o_col,
  input  logic [3:0] i_row,
  output logic [3:0] o_code,
  output logic       o_code_vld,
  output logic       o_key_down
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);

  // ---------------------------------------------------------------------
  // Row synchroniser
  // ---------------------------------------------------------------------
  logic [N_ROWS-1:0] row_sync_s;

  keypad_row_sync u_row_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_row (i_row),
    .o_row (row_sync_s)
  );

  // ---------------------------------------------------------------------
  // Column scan counter
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q;
  logic [1:0]       col_idx_q;
  logic [1:0]       col_idx_d;
  logic [3:0]       col_q;
  logic             sample_s;
  logic             col_last_s;

  // Rows are sampled in the last clock of each column, giving the
  // synchroniser SCAN_DIV-1 clocks to settle after the column switch.
  assign sample_s   = (div_cnt_q == DIV_LAST);
  assign col_last_s = (col_idx_q == 2'd3);
  assign col_idx_d  = col_idx_q + 2'd1;

  // Divider and column index; column drive is registered alongside the index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_cnt_q <= '0;
      col_idx_q <= 2'd0;
      col_q     <= 4'b1110;
    end else if (sample_s) begin
      div_cnt_q <= '0;
      col_idx_q <= col_idx_d;
      col_q     <= ~(4'b0001 << col_idx_d);
    end else begin
      div_cnt_q <= div_cnt_q + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Frame accumulation and classification
  // ---------------------------------------------------------------------
  logic [N_ROWS-1:0] col_hits_s;
  logic [2:0]        col_cnt_s;
  key_code_t         col_key_s;
  logic [2:0]        sum_s;
  logic [1:0]        merged_cnt_s;
  key_code_t         best_key_s;
  frame_kind_e       merged_kind_s;

  logic [1:0]        acc_cnt_q;     // keys seen so far in this frame, saturating at 2
  key_code_t         acc_key_q;     // lowest key index seen so far in this frame
  logic              frame_vld_q;
  frame_kind_e       frame_kind_q;
  key_code_t         frame_key_q;

  assign col_hits_s = ~row_sync_s;
  assign col_cnt_s  = row_hit_count(col_hits_s);
  assign col_key_s  = {lowest_row(col_hits_s), col_idx_q};

  // Merge the current column sample into the running frame summary.
  always_comb begin
    sum_s         = {1'b0, acc_cnt_q} + col_cnt_s;
    merged_cnt_s  = 2'd0;
    best_key_s    = acc_key_q;
    merged_kind_s = FR_NONE;

    if (sum_s >= 3'd2) begin
      merged_cnt_s = 2'd2;
    end else begin
      merged_cnt_s = sum_s[1:0];
    end

    if ((col_cnt_s != 3'd0) && ((acc_cnt_q == 2'd0) || (col_key_s < acc_key_q))) begin
      best_key_s = col_key_s;
    end else begin
      best_key_s = acc_key_q;
    end

    case (merged_cnt_s)
      2'd0:    merged_kind_s = FR_NONE;
      2'd1:    merged_kind_s = FR_SINGLE;
`ifdef KEYPAD_GHOST_REJECT_EN
      default: merged_kind_s = FR_MULTI;
`else
      default: merged_kind_s = FR_SINGLE;
`endif
    endcase
  end

  // Accumulate per-column samples; publish the frame result at the column-3 sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_cnt_q    <= 2'd0;
      acc_key_q    <= 4'd0;
      frame_vld_q  <= 1'b0;
      frame_kind_q <= FR_NONE;
      frame_key_q  <= 4'd0;
    end else begin
      frame_vld_q <= 1'b0;
      if (sample_s) begin
        if (col_last_s) begin
          frame_vld_q  <= 1'b1;
          frame_kind_q <= merged_kind_s;
          frame_key_q  <= best_key_s;
          acc_cnt_q    <= 2'd0;
          acc_key_q    <= 4'd0;
        end else begin
          acc_cnt_q <= merged_cnt_s;
          acc_key_q <= best_key_s;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------
  scan_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_s;
  key_code_t        cand_q;
  key_code_t        code_q;
  logic             code_vld_q;
  logic             key_down_q;

  // cnt never exceeds DEBOUNCE_SCANS-1 where it is incremented, so no wrap.
  assign cnt_inc_s = cnt_q + CNT_W'(1);

  // Frame-level debounce; acts once per frame, one clock after the result lands.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cand_q     <= 4'd0;
      code_q     <= 4'd0;
      code_vld_q <= 1'b0;
      key_down_q <= 1'b0;
    end else begin
      code_vld_q <= 1'b0;
      if (frame_vld_q) begin
        case (state_q)
          ST_IDLE: begin
            if (frame_kind_q == FR_SINGLE) begin
              if (DEBOUNCE_SCANS == 1) begin
                state_q    <= ST_PRESSED;
                cnt_q      <= CNT_TARGET;
                cand_q     <= frame_key_q;
                code_q     <= frame_key_q;
                code_vld_q <= 1'b1;
                key_down_q <= 1'b1;
              end else begin
                state_q <= ST_CAND;
                cand_q  <= frame_key_q;
                cnt_q   <= CNT_W'(1);
              end
            end else begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end
          end
          ST_CAND: begin
            if ((frame_kind_q == FR_SINGLE) && (frame_key_q == cand_q)) begin
              if (cnt_inc_s >= CNT_TARGET) begin
                state_q    <= ST_PRESSED;
                cnt_q      <= CNT_TARGET;
                code_q     <= cand_q;
                code_vld_q <= 1'b1;
                key_down_q <= 1'b1;
              end else begin
                cnt_q <= cnt_inc_s;
              end
            end else if (frame_kind_q == FR_SINGLE) begin
              cand_q <= frame_key_q;
              cnt_q  <= CNT_W'(1);
            end else begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end
          end
          ST_PRESSED: begin
            if (frame_kind_q == FR_NONE) begin
              if (DEBOUNCE_SCANS == 1) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                key_down_q <= 1'b0;
              end else begin
                state_q <= ST_RELEASE;
                cnt_q   <= CNT_W'(1);
              end
            end
          end
          ST_RELEASE: begin
            if (frame_kind_q == FR_NONE) begin
              if (cnt_inc_s >= CNT_TARGET) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                key_down_q <= 1'b0;
              end else begin
                cnt_q <= cnt_inc_s;
              end
            end else begin
              // Key came back before the release was confirmed: still the same press.
              state_q <= ST_PRESSED;
              cnt_q   <= CNT_TARGET;
            end
          end
          default: begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            key_down_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_col      = col_q;
  assign o_code     = code_q;
  assign o_code_vld = code_vld_q;
  assign o_key_down = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_DIV=4,
// DEBOUNCE_SCANS=3 (16-clock frames). A behavioural keypad drives i_row from
// o_col and a set of held keys. Expected values are hand-derived; t below is
// clocks since the last reset edge, observed at negedge+1.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  code;
  logic        vld;
  logic        kd;
  logic [15:0] keys = 16'h0000;

  int          total = 0;
  int          bad   = 0;
  logic [3:0]  codes[$];

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .o_col      (col),
    .i_row      (row),
    .o_code     (code),
    .o_code_vld (vld),
    .o_key_down (kd)
  );

  always #5 clk = ~clk;

  // Behavioural keypad: a held key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  // Strobe recorder.
  always @(negedge clk) begin
    if (vld === 1'b1) codes.push_back(code);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    keys = 16'h0000;
    reset_pulse();
  endtask

  task automatic test_reset();
    int         base;
    logic [3:0] one;
    logic [3:0] exp_col;
    do_reset();
    base = codes.size();
    total++; if (col !== 4'b1110) begin bad++; $display("FAIL rst_col: got %b want 1110", col); end
    total++; if (code !== 4'h0) begin bad++; $display("FAIL rst_code: got %h want 0", code); end
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL rst_vld: got %b want 0", vld); end
    total++; if (kd !== 1'b0) begin bad++; $display("FAIL rst_keydown: got %b want 0", kd); end
    one = 4'b0001;
    for (int t = 0; t < 160; t++) begin
      exp_col = ~(one << ((t / 4) % 4));
      total++; if (col !== exp_col) begin bad++; $display("FAIL idle_col t=%0d: got %b want %b", t, col, exp_col); end
      step(1);
    end
    total++; if (codes.size() != base) begin bad++; $display("FAIL idle_strobes: got %0d want 0", codes.size() - base); end
  endtask

  task automatic test_hold_release();
    int base;
    do_reset();
    base = codes.size();
    keys = 16'h0040;  // row 1, col 2
    step(48);
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL hold_vld_early: got %b want 0", vld); end
    total++; if (kd !== 1'b0) begin bad++; $display("FAIL hold_kd_early: got %b want 0", kd); end
    step(1);  // t=49
    total++; if (vld !== 1'b1) begin bad++; $display("FAIL hold_vld: got %b want 1", vld); end
    total++; if (code !== 4'h6) begin bad++; $display("FAIL hold_code: got %h want 6", code); end
    total++; if (kd !== 1'b1) begin bad++; $display("FAIL hold_kd_rise: got %b want 1", kd); end
    step(1);  // t=50
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL hold_vld_width: got %b want 0", vld); end
    step(78); // t=128, 8 frames held
    total++; if (kd !== 1'b1) begin bad++; $display("FAIL hold_kd_held: got %b want 1", kd); end
    total++; if (codes.size() - base != 1) begin bad++; $display("FAIL hold_count: got %0d want 1", codes.size() - base); end
    keys = 16'h0000;
    step(48); // t=176
    total++; if (kd !== 1'b1) begin bad++; $display("FAIL rel_kd_before: got %b want 1", kd); end
    step(1);  // t=177, third NONE frame processed
    total++; if (kd !== 1'b0) begin bad++; $display("FAIL rel_kd_fall: got %b want 0", kd); end
    step(31); // t=208, 5 frames released
    total++; if (codes.size() - base != 1) begin bad++; $display("FAIL rel_count: got %0d want 1", codes.size() - base); end
    total++; if (code !== 4'h6) begin bad++; $display("FAIL rel_code_hold: got %h want 6", code); end
  endtask

  task automatic test_bounce();
    int base;
    do_reset();
    base = codes.size();
    for (int f = 0; f < 10; f++) begin
      keys = (f % 2 == 0) ? 16'h0200 : 16'h0000;  // key 9 = row 2, col 1
      step(16);
      total++; if (kd !== 1'b0) begin bad++; $display("FAIL bounce_kd f=%0d: got %b want 0", f, kd); end
    end
    keys = 16'h0000;
    step(32);
    total++; if (codes.size() != base) begin bad++; $display("FAIL bounce_count: got %0d want 0", codes.size() - base); end
  endtask

  task automatic test_back_to_back();
    int          base;
    logic [3:0]  seq [4];
    logic [15:0] one16;
    do_reset();
    base   = codes.size();
    seq[0] = 4'h2; seq[1] = 4'h3; seq[2] = 4'h2; seq[3] = 4'h7;
    one16  = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      keys = one16 << seq[i];
      step(64);
      total++; if (kd !== 1'b1) begin bad++; $display("FAIL seq_kd i=%0d: got %b want 1", i, kd); end
      keys = 16'h0000;
      step(64);
      total++; if (kd !== 1'b0) begin bad++; $display("FAIL seq_kd_rel i=%0d: got %b want 0", i, kd); end
    end
    total++; if (codes.size() - base != 4) begin bad++; $display("FAIL seq_count: got %0d want 4", codes.size() - base); end
    for (int i = 0; i < 4; i++) begin
      if (base + i < codes.size()) begin
        total++; if (codes[base+i] !== seq[i]) begin bad++; $display("FAIL seq_code i=%0d: got %h want %h", i, codes[base+i], seq[i]); end
      end
    end
  endtask

  task automatic test_ghost();
    int base;
    do_reset();
    base = codes.size();
    keys = 16'h0012;  // keys 1 and 4 together
    step(96);
`ifdef KEYPAD_GHOST_REJECT_EN
    total++; if (kd !== 1'b0) begin bad++; $display("FAIL ghost_kd: got %b want 0", kd); end
`else
    total++; if (kd !== 1'b1) begin bad++; $display("FAIL ghost_kd: got %b want 1", kd); end
`endif
    keys = 16'h0000;
    step(64);
`ifdef KEYPAD_GHOST_REJECT_EN
    total++; if (codes.size() != base) begin bad++; $display("FAIL ghost_count: got %0d want 0", codes.size() - base); end
`else
    total++; if (codes.size() - base != 1) begin bad++; $display("FAIL ghost_count: got %0d want 1", codes.size() - base); end
    total++; if (code !== 4'h1) begin bad++; $display("FAIL ghost_code: got %h want 1", code); end
`endif
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    base = codes.size();
    keys = 16'h0020;  // key 5 = row 1, col 1
    step(34);         // two SINGLE frames processed: CAND, cnt=2
    reset_pulse();    // new origin t=0, key still held
    total++; if (col !== 4'b1110) begin bad++; $display("FAIL mid_col: got %b want 1110", col); end
    total++; if (code !== 4'h0) begin bad++; $display("FAIL mid_code: got %h want 0", code); end
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL mid_vld: got %b want 0", vld); end
    total++; if (kd !== 1'b0) begin bad++; $display("FAIL mid_kd: got %b want 0", kd); end
    step(1);
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL mid_vld_next: got %b want 0", vld); end
    step(47);         // t=48
    total++; if (codes.size() != base) begin bad++; $display("FAIL mid_early: got %0d want 0", codes.size() - base); end
    total++; if (code !== 4'h0) begin bad++; $display("FAIL mid_code_hold: got %h want 0", code); end
    step(1);          // t=49, third fresh frame processed
    total++; if (vld !== 1'b1) begin bad++; $display("FAIL mid_vld_emit: got %b want 1", vld); end
    total++; if (code !== 4'h5) begin bad++; $display("FAIL mid_code_emit: got %h want 5", code); end
    keys = 16'h0000;
    step(64);
    total++; if (codes.size() - base != 1) begin bad++; $display("FAIL mid_count: got %0d want 1", codes.size() - base); end
  endtask

  initial begin
    test_reset();
    test_hold_release();
    test_bounce();
    test_back_to_back();
    test_ghost();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
